fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
Read-side consumer for the team's synchronous 16-entry byte FIFO. It pops bytes whenever the FIFO is non-empty and the block is enabled, then serializes each byte as an asynchronous 8N1 frame on a single tx line. It connects directly to the FIFO's rd_en, d_out and empty pins. It turns buffered parallel data into a UART stream.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range >= 2
DATA_W, 8, data bits per frame; must match FIFO width

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous, active-low reset
en  input  1  transmit enable; sampled only in IDLE
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DATA_W  FIFO d_out; valid one cycle after a rd_en pulse
fifo_rd_en  output  1  registered one-cycle pop request to FIFO
tx  output  1  serial line, idle high
busy  output  1  high whenever state != IDLE
tx_done  output  1  one-cycle pulse on the cycle the stop bit ends

Behaviour:
- Reset: clk is the clock; rst is synchronous and active-low. While rst=0 at a posedge: tx=1, fifo_rd_en=0, busy=0, tx_done=0, state=IDLE, all counters and the shift register are 0.
- The FSM has six states: IDLE, POP, LOAD, START, DATA, STOP. All outputs are registered.
- IDLE: tx=1. If en=1 and fifo_empty=0, next state is POP and fifo_rd_en=1. Otherwise stay in IDLE.
- POP: fifo_rd_en is high for exactly this one cycle, so the FIFO samples it at the edge that leaves POP. Next state is LOAD, with fifo_rd_en=0.
- LOAD: fifo_data is valid. Capture it into the shift register. Next state is START and tx goes to 0.
- START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: drive tx = shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. Send DATA_W bits, LSB first, then go to STOP.
- STOP: hold tx=1 for CLKS_PER_BIT cycles. On the final cycle pulse tx_done=1 for one cycle, then go to IDLE.
- Counters:
  - The baud counter is $clog2(CLKS_PER_BIT) bits wide, counts 0..CLKS_PER_BIT-1 and resets at each bit boundary.
  - The bit counter is $clog2(DATA_W+1) bits wide.
- Frame length: 1 + DATA_W + 1 bits, which is (DATA_W+2)*CLKS_PER_BIT cycles of tx activity.
- Back-to-back frames: after STOP there are exactly 3 cycles with tx=1 (IDLE, POP, LOAD) before the next start bit, provided the FIFO is non-empty and en=1.
- At most one pop is issued per frame; fifo_rd_en never asserts outside POP. The block never pops while fifo_empty=1 in the IDLE decision cycle.
- Dropping en mid-frame: the current frame completes. No further pop occurs until en=1 in IDLE.
- fifo_empty rising after a pop has no effect on the frame in progress.
- Reset mid-operation:
  - tx returns to 1 at the next edge.
  - Any byte already popped is discarded; it is not re-read.
  - A fifo_rd_en pulse in flight is cleared.
- busy is 1 from POP through the end of STOP.

Optional Feature:
FIFO_UART_TX_PARITY_EN.
- Defined: an even parity bit is inserted between the last data bit and the stop bit. Its value is the XOR of all DATA_W bits, held for CLKS_PER_BIT cycles. This adds a PARITY state between DATA and STOP. Frame length becomes (DATA_W+3)*CLKS_PER_BIT.
- Undefined: no parity state exists and the frame is 8N1 as described above.

Test Plan:
All scenarios use CLKS_PER_BIT=4 and a behavioural FIFO model with one-cycle read latency.
1. Reset: hold rst=0 for 3 cycles with a non-empty FIFO and en=1 -> tx=1, fifo_rd_en=0, busy=0, tx_done=0 throughout.
2. Single byte 0xA5, en=1:
   - exactly one fifo_rd_en pulse;
   - tx=0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 each for 4 cycles, then 1 for 4 cycles;
   - one tx_done pulse;
   - 40 cycles from start bit to end of stop bit.
3. Bytes 0x01, 0x80, 0xFF queued -> three rd_en pulses and three decoded frames matching the queued bytes. Exactly 3 idle-high cycles between frames. The FIFO model is empty afterwards.
4. Empty FIFO, en=1 for 100 cycles -> no fifo_rd_en, tx=1, busy=0.
5. 0x3C and 0x55 queued; drop en during the DATA bits of 0x3C -> 0x3C completes correctly. No pop occurs for 0x55 until en returns high, after which 0x55 is sent.
6. rst=0 for 1 cycle during bit 3 of 0x5A, then 0x66 queued -> tx=1 and busy=0 the cycle after reset. The next frame is 0x66 with a fresh pop; 0x5A is not retransmitted.
7. With FIFO_UART_TX_PARITY_EN defined, byte 0xA5 -> parity bit 0 after the data bits, frame 44 cycles. With byte 0x07 -> parity bit 1.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// FIFO read-side UART transmitter: pops one byte per frame and shifts it out as 8N1, LSB first.
// Define FIFO_UART_TX_PARITY_EN to insert an even parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
`ifdef FIFO_UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t             r_state;
  logic [BAUD_W-1:0]  r_baud;
  logic [BIT_W-1:0]   r_bit;
  logic [DATA_W-1:0]  r_shift;
  logic               r_tx;
  logic               r_rd_en;
  logic               r_busy;
  logic               r_done;
`ifdef FIFO_UART_TX_PARITY_EN
  logic               r_parity;
`endif

  logic               w_baud_end;
  logic [DATA_W-1:0]  w_shift_next;

  assign w_baud_end   = (r_baud == BAUD_LAST);
  assign w_shift_next = r_shift >> 1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
      r_rd_en  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_baud <= '0;
          r_bit  <= '0;
          if (en && !fifo_empty) begin
            r_state <= S_POP;
            r_rd_en <= 1'b1;
            r_busy  <= 1'b1;
          end
        end

        S_POP: begin
          r_state <= S_LOAD;
        end

        // FIFO d_out becomes valid the cycle after the pop edge
        S_LOAD: begin
          r_shift <= fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
          r_parity <= ^fifo_data;
`endif
          r_tx    <= 1'b0;
          r_baud  <= '0;
          r_state <= S_START;
        end

        S_START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        S_DATA: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_shift <= w_shift_next;
            if (r_bit == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_bit <= r_bit + 1'b1;
              r_tx  <= w_shift_next[0];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`endif

        // Done is raised one count early so the registered pulse lands on the last stop cycle
        S_STOP: begin
          r_tx <= 1'b1;
          if (r_baud == BAUD_PRE) begin
            r_done <= 1'b1;
          end
          if (w_baud_end) begin
            r_baud  <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd_en = r_rd_en;
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign tx_done    = r_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural FIFO, tx line decoder and byte scoreboard at CLKS_PER_BIT=4.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif
  localparam int FRAME_CYC = NSLOT * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       tx_done;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous FIFO, one-cycle read latency
  logic       push_v = 1'b0;
  logic [7:0] push_d = 8'h00;
  logic [7:0] fq[$];

  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0) fifo_data <= fq.pop_front();
    if (push_v) fq.push_back(push_d);
    fifo_empty <= (fq.size() == 0);
  end

  // Line decoder: one record per complete frame
  logic       prev_tx = 1'b1;
  logic       mon_active = 1'b0;
  int         mon_idx = 0;
  logic       slot_val[0:15];
  int         slot_err = 0;
  int         done_cnt = 0;
  int         done_idx = -1;
  int         gap_cnt = 0;
  int         cur_gap = 0;
  logic [7:0] rx_byte[0:63];
  int         rx_err[0:63];
  int         rx_len[0:63];
  int         rx_dcnt[0:63];
  int         rx_gap[0:63];
  logic       rx_par[0:63];
  int         rx_wr = 0;

  always @(negedge clk) begin
    if (!rst) begin
      mon_active = 1'b0;
      prev_tx = 1'b1;
      gap_cnt = 0;
    end else if (!mon_active) begin
      if (prev_tx && !tx) begin
        mon_active = 1'b1;
        mon_idx = 0;
        slot_err = 0;
        done_cnt = 0;
        done_idx = -1;
        cur_gap = gap_cnt;
        slot_val[0] = tx;
        if (tx_done) begin
          done_cnt++;
          done_idx = 0;
        end
      end else if (tx) begin
        gap_cnt++;
      end
      prev_tx = tx;
    end else begin
      mon_idx++;
      if (mon_idx % CPB == 0) slot_val[mon_idx / CPB] = tx;
      else if (tx != slot_val[mon_idx / CPB]) slot_err++;
      if (tx_done) begin
        done_cnt++;
        done_idx = mon_idx;
      end
      if (mon_idx == FRAME_CYC - 1) begin
        for (int k = 0; k < 8; k++) rx_byte[rx_wr][k] = slot_val[k + 1];
        rx_err[rx_wr] = slot_err + ((slot_val[0] != 1'b0) ? 1 : 0) + ((slot_val[NSLOT-1] != 1'b1) ? 1 : 0);
        rx_len[rx_wr] = done_idx + 1;
        rx_dcnt[rx_wr] = done_cnt;
        rx_gap[rx_wr] = cur_gap;
        rx_par[rx_wr] = slot_val[9];
        rx_wr++;
        mon_active = 1'b0;
        gap_cnt = 0;
      end
      prev_tx = tx;
    end
  end

  // Main-process state and helpers
  int         n_cmp = 0;
  int         n_err = 0;
  int         rd_cnt = 0;
  int         busy_cnt = 0;
  int         txlo_cnt = 0;
  int         rx_rd = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, act);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (fifo_rd_en) rd_cnt++;
    if (busy) busy_cnt++;
    if (!tx) txlo_cnt++;
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_q.push_back(b);
    tick();
    push_v = 1'b1;
    push_d = b;
    tick();
    push_v = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (rx_wr < target && n < budget) begin
      tick();
      n++;
    end
    chk("frames_seen", rx_wr, target);
  endtask

  task automatic wait_idx(input int idx, input int budget);
    int n = 0;
    while (!(mon_active && mon_idx >= idx) && n < budget) begin
      tick();
      n++;
    end
    chk("frame_reached", int'(mon_active && mon_idx >= idx), 1);
  endtask

  task automatic compare_next(input string tag);
    logic [7:0] e;
    chk({tag, "_expq"}, int'(exp_q.size() > 0), 1);
    if (rx_rd < rx_wr && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_byte"}, int'(rx_byte[rx_rd]), int'(e));
      chk({tag, "_bits"}, rx_err[rx_rd], 0);
      chk({tag, "_done"}, rx_dcnt[rx_rd], 1);
      chk({tag, "_len"}, rx_len[rx_rd], FRAME_CYC);
      rx_rd++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset held with a non-empty FIFO and en=1
    rst = 1'b0;
    en = 1'b1;
    push_byte(8'hA5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_tx", int'(tx), 1);
      chk("rst_rd_en", int'(fifo_rd_en), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(tx_done), 0);
    end

    // 2: single byte 0xA5
    rd_cnt = 0;
    rst = 1'b1;
    wait_frames(1, 200);
    compare_next("t2");
    repeat (4) tick();
    chk("t2_rd_pulses", rd_cnt, 1);
    chk("t2_idle_busy", int'(busy), 0);
    chk("t2_idle_tx", int'(tx), 1);

    // 3: back-to-back frames
    rd_cnt = 0;
    push_byte(8'h01);
    push_byte(8'h80);
    push_byte(8'hFF);
    wait_frames(rx_rd + 3, 500);
    chk("t3_gap2", rx_gap[rx_rd + 1], 3);
    chk("t3_gap3", rx_gap[rx_rd + 2], 3);
    compare_next("t3a");
    compare_next("t3b");
    compare_next("t3c");
    repeat (4) tick();
    chk("t3_rd_pulses", rd_cnt, 3);
    chk("t3_fifo_empty", int'(fifo_empty), 1);

    // 4: empty FIFO with en=1
    rd_cnt = 0;
    busy_cnt = 0;
    txlo_cnt = 0;
    repeat (100) tick();
    chk("t4_rd_pulses", rd_cnt, 0);
    chk("t4_busy_cycles", busy_cnt, 0);
    chk("t4_tx_low_cycles", txlo_cnt, 0);

    // 5: en dropped mid-frame
    rd_cnt = 0;
    push_byte(8'h3C);
    push_byte(8'h55);
    wait_idx(6, 100);
    en = 1'b0;
    wait_frames(rx_rd + 1, 200);
    compare_next("t5a");
    repeat (60) tick();
    chk("t5_rd_hold", rd_cnt, 1);
    chk("t5_no_frame", rx_wr, rx_rd);
    en = 1'b1;
    wait_frames(rx_rd + 1, 200);
    compare_next("t5b");
    chk("t5_rd_pulses", rd_cnt, 2);

    // 6: reset during bit 3 of 0x5A
    repeat (4) tick();
    rd_cnt = 0;
    push_byte(8'h5A);
    wait_idx(4 + 3 * CPB + 1, 100);
    rst = 1'b0;
    tick();
    chk("t6_tx_after_rst", int'(tx), 1);
    chk("t6_busy_after_rst", int'(busy), 0);
    chk("t6_rd_after_rst", int'(fifo_rd_en), 0);
    rst = 1'b1;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    push_byte(8'h66);
    wait_frames(rx_rd + 1, 200);
    compare_next("t6");
    chk("t6_rd_pulses", rd_cnt, 2);
    chk("t6_fifo_empty", int'(fifo_empty), 1);

`ifdef FIFO_UART_TX_PARITY_EN
    // 7: parity bit values
    repeat (4) tick();
    push_byte(8'hA5);
    wait_frames(rx_rd + 1, 200);
    chk("t7_par_a5", int'(rx_par[rx_rd]), 0);
    compare_next("t7a");
    push_byte(8'h07);
    wait_frames(rx_rd + 1, 200);
    chk("t7_par_07", int'(rx_par[rx_rd]), 1);
    compare_next("t7b");
`endif

    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
